// File: rtl/sram_dualport_pipelined_if.sv
// ---------------------------------------------------------------------------
// sram_dualport_pipelined_if
// Request/response bundle between a FIFO controller (master) and the
// pipelined dual-port SRAM (slave).
//   wen_i   write enable            (master -> slave)
//   ren_i   read enable             (master -> slave)
//   waddr_i write address, AW bits  (master -> slave)
//   raddr_i read address, AW bits   (master -> slave)
//   data_i  write data, WIDTH bits  (master -> slave)
//   data_o  read data, WIDTH bits   (slave -> master)
//   vld_o   read data valid strobe  (slave -> master)
// Signal names keep the memory's _i/_o view so they read the same on
// both sides of the connection.
// ---------------------------------------------------------------------------
interface sram_dualport_pipelined_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             wen_i;
    logic             ren_i;
    logic [AW-1:0]    waddr_i;
    logic [AW-1:0]    raddr_i;
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] data_o;
    logic             vld_o;

    modport master (
        output wen_i, ren_i, waddr_i, raddr_i, data_i,
        input  data_o, vld_o
    );

    modport slave (
        input  wen_i, ren_i, waddr_i, raddr_i, data_i,
        output data_o, vld_o
    );
endinterface

// File: rtl/sram_dualport_pipelined.sv
// ---------------------------------------------------------------------------
// sram_dualport_pipelined
// Behavioural dual-port SRAM with one write port, one read port and a fixed
// read latency of LATENCY cycles. Reads return in issue order with a
// one-cycle vld_o pulse each; data_o holds the last returned word between
// pulses.
//   clk_i  clock, all state changes on the rising edge
//   rst_i  asynchronous active-high reset (clears read pipeline only)
//   bus    sram_dualport_pipelined_if.slave: wen_i, ren_i, waddr_i,
//          raddr_i, data_i in; data_o, vld_o out
// Parameters: WIDTH (word bits), DEPTH (words, >= 2), LATENCY (>= 1).
// ---------------------------------------------------------------------------
module sram_dualport_pipelined #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    sram_dualport_pipelined_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    // One extra bit so DEPTH itself is representable for range checks
    // when DEPTH is not a power of two.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    generate
        if (LATENCY < 1) begin : g_latency_check
            $error("sram_dualport_pipelined: LATENCY must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               waddrValid;
    logic               raddrValid;
    logic [WIDTH-1:0]   readWord;

    logic [LATENCY-1:0] stageVld_q;
    logic [LATENCY-1:0] stageVld_d;
    logic [WIDTH-1:0]   stageData_q [LATENCY];
    logic [WIDTH-1:0]   stageData_d [LATENCY];

    assign waddrValid = ({1'b0, bus.waddr_i} < DEPTH_W);
    assign raddrValid = ({1'b0, bus.raddr_i} < DEPTH_W);

    // Out-of-range reads still produce a response, carrying zero.
    assign readWord = raddrValid ? mem_q[bus.raddr_i] : '0;

    // Storage array: deliberately not reset, contents survive rst_i.
    // Out-of-range writes are dropped. Because the read sample above uses
    // the pre-edge contents, a same-edge read/write is read-first.
    always_ff @(posedge clk_i) begin
        if (bus.wen_i && waddrValid) begin
            mem_q[bus.waddr_i] <= bus.data_i;
        end
    end

    // Read pipeline next state: valid bits shift unconditionally, and each
    // data stage only loads when the valid bit entering it is set, so the
    // last stage keeps the most recent returned word while idle.
    always_comb begin
        stageVld_d  = '0;
        stageData_d = stageData_q;
        stageVld_d[0] = bus.ren_i;
        if (bus.ren_i) begin
            stageData_d[0] = readWord;
        end
        for (int s = 1; s < LATENCY; s++) begin
            stageVld_d[s] = stageVld_q[s-1];
            if (stageVld_q[s-1]) begin
                stageData_d[s] = stageData_q[s-1];
            end
        end
    end

    // Pipeline registers: reset discards every in-flight read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stageVld_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                stageData_q[s] <= '0;
            end
        end else begin
            stageVld_q  <= stageVld_d;
            stageData_q <= stageData_d;
        end
    end

    assign bus.vld_o  = stageVld_q[LATENCY-1];
    assign bus.data_o = stageData_q[LATENCY-1];
endmodule

// File: tb/tb_sram_dualport_pipelined.sv
// ---------------------------------------------------------------------------
// tb_sram_dualport_pipelined
// Drives four SRAM instances with one shared stimulus stream:
//   dut 0: DEPTH 8, LATENCY 5
//   dut 1: DEPTH 8, LATENCY 2
//   dut 2: DEPTH 8, LATENCY 1
//   dut 3: DEPTH 6, LATENCY 1 (addresses 6 and 7 are out of range)
// Every read pushes an expected {due edge, data} entry per instance; the
// entries are popped and compared when vld_o appears.
// ---------------------------------------------------------------------------
module tb_sram_dualport_pipelined;
    localparam int NDUT = 4;
    localparam int LAT [NDUT] = '{5, 2, 1, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [2:0] waddr = '0;
    logic [2:0] raddr = '0;
    logic [7:0] wdata = '0;

    always #5 clk = ~clk;

    sram_dualport_pipelined_if #(.WIDTH(8), .DEPTH(8)) busL5 ();
    sram_dualport_pipelined_if #(.WIDTH(8), .DEPTH(8)) busL2 ();
    sram_dualport_pipelined_if #(.WIDTH(8), .DEPTH(8)) busL1 ();
    sram_dualport_pipelined_if #(.WIDTH(8), .DEPTH(6)) busD6 ();

    assign busL5.wen_i = wen;  assign busL5.ren_i = ren;  assign busL5.waddr_i = waddr;
    assign busL5.raddr_i = raddr;  assign busL5.data_i = wdata;
    assign busL2.wen_i = wen;  assign busL2.ren_i = ren;  assign busL2.waddr_i = waddr;
    assign busL2.raddr_i = raddr;  assign busL2.data_i = wdata;
    assign busL1.wen_i = wen;  assign busL1.ren_i = ren;  assign busL1.waddr_i = waddr;
    assign busL1.raddr_i = raddr;  assign busL1.data_i = wdata;
    assign busD6.wen_i = wen;  assign busD6.ren_i = ren;  assign busD6.waddr_i = waddr;
    assign busD6.raddr_i = raddr;  assign busD6.data_i = wdata;

    sram_dualport_pipelined #(.WIDTH(8), .DEPTH(8), .LATENCY(5)) dutL5 (
        .clk_i(clk), .rst_i(rst), .bus(busL5.slave));
    sram_dualport_pipelined #(.WIDTH(8), .DEPTH(8), .LATENCY(2)) dutL2 (
        .clk_i(clk), .rst_i(rst), .bus(busL2.slave));
    sram_dualport_pipelined #(.WIDTH(8), .DEPTH(8), .LATENCY(1)) dutL1 (
        .clk_i(clk), .rst_i(rst), .bus(busL1.slave));
    sram_dualport_pipelined #(.WIDTH(8), .DEPTH(6), .LATENCY(1)) dutD6 (
        .clk_i(clk), .rst_i(rst), .bus(busD6.slave));

    logic       vldA  [NDUT];
    logic [7:0] dataA [NDUT];
    assign vldA[0] = busL5.vld_o;  assign dataA[0] = busL5.data_o;
    assign vldA[1] = busL2.vld_o;  assign dataA[1] = busL2.data_o;
    assign vldA[2] = busL1.vld_o;  assign dataA[2] = busL1.data_o;
    assign vldA[3] = busD6.vld_o;  assign dataA[3] = busD6.data_o;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic       w;
        logic       r;
        logic [2:0] wa;
        logic [2:0] ra;
        logic [7:0] wd;
        logic [7:0] expData;
    } vec_t;

    exp_t       expQ [NDUT][$];
    vec_t       vecs [$];
    logic [7:0] mem8 [8];
    logic [7:0] mem6 [6];
    logic [7:0] lastData [NDUT];
    int         vldCount [NDUT];
    int         readCount [NDUT];
    int         edgeNum = 0;
    int         errors = 0;
    int         checks = 0;

    // Compare every instance's outputs against the scoreboard heads.
    task automatic checkOutput();
        exp_t e;
        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (vldA[i]) begin
                vldCount[i]++;
                if (expQ[i].size() == 0) begin
                    errors++;
                    $display("[TB] FAIL spurious_vld dut%0d: got vld_o=1 data_o=%02h at edge %0d, required vld_o=0",
                             i, dataA[i], edgeNum);
                end else begin
                    e = expQ[i].pop_front();
                    if (e.due != edgeNum || dataA[i] !== e.data) begin
                        errors++;
                        $display("[TB] FAIL read dut%0d: got data_o=%02h at edge %0d, required %02h at edge %0d",
                                 i, dataA[i], edgeNum, e.data, e.due);
                    end
                    lastData[i] = e.data;
                end
            end else if (expQ[i].size() != 0 && expQ[i][0].due <= edgeNum) begin
                errors++;
                $display("[TB] FAIL missing_vld dut%0d: got vld_o=0 at edge %0d, required vld_o=1 data_o=%02h",
                         i, edgeNum, expQ[i][0].data);
                void'(expQ[i].pop_front());
            end else if (dataA[i] !== lastData[i]) begin
                errors++;
                $display("[TB] FAIL hold_data dut%0d: got data_o=%02h with vld_o=0, required %02h",
                         i, dataA[i], lastData[i]);
            end
        end
    endtask

    // Drive one cycle of stimulus, record expectations at the sampling edge
    // (read-first: the model memory is updated after the read is captured),
    // then check outputs on the falling edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [2:0] wa,
                                 input logic [2:0] ra, input logic [7:0] wd,
                                 input logic useExp, input logic [7:0] expD);
        exp_t e;
        wen = w; ren = r; waddr = wa; raddr = ra; wdata = wd;
        @(posedge clk);
        edgeNum++;
        if (r) begin
            for (int i = 0; i < NDUT; i++) begin
                if (i == 3)
                    e.data = (ra < 3'd6) ? mem6[ra] : 8'h00;
                else
                    e.data = useExp ? expD : mem8[ra];
                e.due = edgeNum + LAT[i] - 1;
                expQ[i].push_back(e);
                readCount[i]++;
            end
        end
        if (w) begin
            mem8[wa] = wd;
            if (wa < 3'd6) mem6[wa] = wd;
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h00);
    endtask

    // Asynchronous reset for one clock: in-flight reads are dropped from
    // the scoreboard, outputs must read zero immediately.
    task automatic doReset();
        wen = 1'b0; ren = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            readCount[i] -= expQ[i].size();
            expQ[i].delete();
            lastData[i] = 8'h00;
        end
        #1;
        checkOutput();
        @(posedge clk);
        edgeNum++;
        @(negedge clk);
        checkOutput();
        rst = 1'b0;
    endtask

    task automatic addVec(input logic w, input logic r, input logic [2:0] wa,
                          input logic [2:0] ra, input logic [7:0] wd, input logic [7:0] ex);
        vec_t v;
        v.w = w; v.r = r; v.wa = wa; v.ra = ra; v.wd = wd; v.expData = ex;
        vecs.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            lastData[i] = 8'h00; vldCount[i] = 0; readCount[i] = 0;
        end
        for (int a = 0; a < 8; a++) mem8[a] = 8'h00;
        for (int a = 0; a < 6; a++) mem6[a] = 8'h00;

        // Directed table: single write/read latency, streaming, read-during-write.
        addVec(1'b1, 1'b0, 3'd3, 3'd0, 8'hA5, 8'h00);
        addVec(1'b0, 1'b1, 3'd0, 3'd3, 8'h00, 8'hA5);
        for (int k = 0; k < 7; k++) addVec(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00);
        for (int a = 0; a < 8; a++) addVec(1'b1, 1'b0, 3'(a), 3'd0, 8'(8'h10 + a), 8'h00);
        for (int a = 0; a < 8; a++) addVec(1'b0, 1'b1, 3'd0, 3'(a), 8'h00, 8'(8'h10 + a));
        for (int k = 0; k < 7; k++) addVec(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00);
        addVec(1'b1, 1'b0, 3'd5, 3'd0, 8'h11, 8'h00);
        addVec(1'b1, 1'b1, 3'd5, 3'd5, 8'h22, 8'h11);
        addVec(1'b0, 1'b1, 3'd0, 3'd5, 8'h00, 8'h22);
        for (int k = 0; k < 6; k++) addVec(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00);

        doReset();
        idle(2);
        for (int n = 0; n < vecs.size(); n++)
            applyStimulus(vecs[n].w, vecs[n].r, vecs[n].wa, vecs[n].ra, vecs[n].wd, 1'b1, vecs[n].expData);

        // Reset with three reads in flight; contents must survive.
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd0, 8'h00, 1'b1, 8'h10);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd1, 8'h00, 1'b1, 8'h11);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd2, 8'h00, 1'b1, 8'h12);
        doReset();
        idle(8);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd1, 8'h00, 1'b1, 8'h11);
        idle(6);

        // Address 7: valid on DEPTH 8, dropped/zero on DEPTH 6.
        applyStimulus(1'b1, 1'b0, 3'd7, 3'd0, 8'hFF, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 3'd0, 3'd7, 8'h00, 1'b1, 8'hFF);
        for (int a = 0; a < 6; a++)
            applyStimulus(1'b0, 1'b1, 3'd0, 3'(a), 8'h00, 1'b0, 8'h00);
        idle(6);

        // Random concurrent traffic against the reference model.
        for (int k = 0; k < 2000; k++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          8'($urandom_range(0, 255)), 1'b0, 8'h00);
        idle(8);

        for (int i = 0; i < NDUT; i++) begin
            checks++;
            if (vldCount[i] != readCount[i] || expQ[i].size() != 0) begin
                errors++;
                $display("[TB] FAIL vld_count dut%0d: got %0d pulses (%0d pending), required %0d",
                         i, vldCount[i], expQ[i].size(), readCount[i]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
